program_writer: RTL and testbench

//  Encoder/loader side of the 8-bit instruction format consumed by the control decoder.

---
 rtl/nic8_isa_pkg.sv | 45 ++++
 rtl/program_writer_if.sv | 39 +++
 rtl/op_encode.sv | 21 ++
 rtl/program_writer.sv | 134 +++++++++++++
 tb/tb_program_writer.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/nic8_isa_pkg.sv
// ============================================================================
// nic8_isa_pkg : field codes, opcode width and encoder for the 8-bit ISA
// Rev 1.0
// ============================================================================
`default_nettype none

package nic8_isa_pkg;

    localparam int OPC_W = 8;

    localparam logic [2:0] SRC_IMM  = 3'd0;
    localparam logic [2:0] SRC_ZERO = 3'd1;
    localparam logic [2:0] SRC_A    = 3'd2;
    localparam logic [2:0] SRC_B    = 3'd3;
    localparam logic [2:0] SRC_X    = 3'd4;
    localparam logic [2:0] SRC_M    = 3'd5;
    localparam logic [2:0] SRC_E    = 3'd6;
    localparam logic [2:0] SRC_S    = 3'd7;

    localparam logic [2:0] DST_IR   = 3'd0;
    localparam logic [2:0] DST_PC   = 3'd1;
    localparam logic [2:0] DST_A    = 3'd2;
    localparam logic [2:0] DST_B    = 3'd3;
    localparam logic [2:0] DST_X    = 3'd4;
    localparam logic [2:0] DST_M    = 3'd5;
    localparam logic [2:0] DST_Q    = 3'd6;
    localparam logic [2:0] DST_QHI  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OP   = 2'd1,
        ST_IMM  = 2'd2,
        ST_FULL = 2'd3
    } pw_state_e;

    function automatic logic [OPC_W-1:0] encode_op(input logic       bit7,
                                                   input logic [2:0] dst,
                                                   input logic       bit3,
                                                   input logic [2:0] src);
        return {bit7, dst, bit3, src};
    endfunction

endpackage

`default_nettype wire

// File: rtl/program_writer_if.sv
// ============================================================================
// program_writer_if : request, origin and memory-write bundle of program_writer
// Rev 1.0
// ============================================================================
`default_nettype none

interface program_writer_if #(
    parameter int ADDR_W = 8
) ();
    logic              org_valid;
    logic [ADDR_W-1:0] org_addr;
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_src;
    logic [2:0]        req_dst;
    logic              req_bit3;
    logic              req_bit7;
    logic [7:0]        req_imm;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [ADDR_W-1:0] next_addr;
    logic              full;
    logic              overflow;

    modport master (
        output org_valid, org_addr, req_valid, req_src, req_dst,
               req_bit3, req_bit7, req_imm,
        input  req_ready, mem_we, mem_addr, mem_wdata, next_addr, full, overflow
    );

    modport slave (
        input  org_valid, org_addr, req_valid, req_src, req_dst,
               req_bit3, req_bit7, req_imm,
        output req_ready, mem_we, mem_addr, mem_wdata, next_addr, full, overflow
    );
endinterface

`default_nettype wire

// File: rtl/op_encode.sv
// ============================================================================
// op_encode : combinational packer of {bit7, dst, bit3, src} into an opcode
// Rev 1.0
// ============================================================================
`default_nettype none

module op_encode
    import nic8_isa_pkg::*;
(
    input  wire logic [2:0]       src_i,
    input  wire logic [2:0]       dst_i,
    input  wire logic             bit3_i,
    input  wire logic             bit7_i,
    output logic      [OPC_W-1:0] opcode_o
);

    assign opcode_o = encode_op(bit7_i, dst_i, bit3_i, src_i);

endmodule

`default_nettype wire

// File: rtl/program_writer.sv
// ============================================================================
// program_writer : encodes transfer requests and streams opcode/immediate bytes
//                  sequentially into program memory
// Rev 1.0
// ============================================================================
`default_nettype none

module program_writer
    import nic8_isa_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter bit ALLOW_WRAP = 1'b0
) (
    input  wire logic       clk,
    input  wire logic       reset,
    program_writer_if.slave bus
);

    localparam logic [ADDR_W-1:0] PTR_MAX = '1;

    pw_state_e         state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [7:0]        imm_q, imm_d;
    logic              imm_pend_q, imm_pend_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              overflow_q, overflow_d;

    logic [OPC_W-1:0]  opcode;
    logic              needs_imm;
    logic              no_room;
    logic              last_written;
    logic              ready;

    op_encode u_op_encode (
        .src_i    (bus.req_src),
        .dst_i    (bus.req_dst),
        .bit3_i   (bus.req_bit3),
        .bit7_i   (bus.req_bit7),
        .opcode_o (opcode)
    );

    assign needs_imm    = (bus.req_src == SRC_IMM);
    assign ready        = ((state_q == ST_IDLE) || (state_q == ST_FULL)) && !bus.org_valid;
    // In IDLE at least one byte is always free, so only an imm instr at the top can fail.
    assign no_room      = (ALLOW_WRAP == 1'b0) &&
                          ((state_q == ST_FULL) || (needs_imm && (ptr_q == PTR_MAX)));
    // Pointer has wrapped to zero exactly when the byte just written sat at the top.
    assign last_written = (ALLOW_WRAP == 1'b0) && (ptr_q == '0);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        imm_d       = imm_q;
        imm_pend_d  = imm_pend_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        overflow_d  = overflow_q;

        case (state_q)
            ST_IDLE, ST_FULL: begin
                if (bus.org_valid) begin
                    ptr_d   = bus.org_addr;
                    state_d = ST_IDLE;
                end else if (bus.req_valid) begin
                    if (no_room) begin
                        overflow_d = 1'b1;
                    end else begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = ptr_q;
                        mem_wdata_d = opcode;
                        ptr_d       = ptr_q + 1'b1;
                        imm_d       = bus.req_imm;
                        imm_pend_d  = needs_imm;
                        state_d     = ST_OP;
                    end
                end
            end
            ST_OP: begin
                if (imm_pend_q) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = ptr_q;
                    mem_wdata_d = imm_q;
                    ptr_d       = ptr_q + 1'b1;
                    imm_pend_d  = 1'b0;
                    state_d     = ST_IMM;
                end else begin
                    state_d = last_written ? ST_FULL : ST_IDLE;
                end
            end
            ST_IMM: begin
                state_d = last_written ? ST_FULL : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            imm_q       <= '0;
            imm_pend_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            imm_q       <= imm_d;
            imm_pend_q  <= imm_pend_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            overflow_q  <= overflow_d;
        end
    end

    assign bus.req_ready = ready;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.next_addr = ptr_q;
    assign bus.full      = (state_q == ST_FULL);
    assign bus.overflow  = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_program_writer.sv
// ============================================================================
// tb_program_writer : three configurations driven by one shared request stream
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_program_writer;
    import nic8_isa_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       org_valid, req_valid, req_bit3, req_bit7;
    logic [7:0] org_addr, req_imm;
    logic [2:0] req_src, req_dst;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // index 0: ADDR_W=8 no wrap, 1: ADDR_W=4 no wrap, 2: ADDR_W=8 wrap
    program_writer_if #(.ADDR_W(8)) bus8 ();
    program_writer_if #(.ADDR_W(4)) bus4 ();
    program_writer_if #(.ADDR_W(8)) busw ();

    assign bus8.org_valid = org_valid;  assign bus8.org_addr = org_addr;
    assign bus8.req_valid = req_valid;  assign bus8.req_src  = req_src;
    assign bus8.req_dst   = req_dst;    assign bus8.req_bit3 = req_bit3;
    assign bus8.req_bit7  = req_bit7;   assign bus8.req_imm  = req_imm;
    assign bus4.org_valid = org_valid;  assign bus4.org_addr = org_addr[3:0];
    assign bus4.req_valid = req_valid;  assign bus4.req_src  = req_src;
    assign bus4.req_dst   = req_dst;    assign bus4.req_bit3 = req_bit3;
    assign bus4.req_bit7  = req_bit7;   assign bus4.req_imm  = req_imm;
    assign busw.org_valid = org_valid;  assign busw.org_addr = org_addr;
    assign busw.req_valid = req_valid;  assign busw.req_src  = req_src;
    assign busw.req_dst   = req_dst;    assign busw.req_bit3 = req_bit3;
    assign busw.req_bit7  = req_bit7;   assign busw.req_imm  = req_imm;

    program_writer #(.ADDR_W(8), .ALLOW_WRAP(1'b0)) u_dut8 (.clk(clk), .reset(rst), .bus(bus8.slave));
    program_writer #(.ADDR_W(4), .ALLOW_WRAP(1'b0)) u_dut4 (.clk(clk), .reset(rst), .bus(bus4.slave));
    program_writer #(.ADDR_W(8), .ALLOW_WRAP(1'b1)) u_dutw (.clk(clk), .reset(rst), .bus(busw.slave));

    // ---------------- behavioural model: byte stream + free-space arithmetic
    int m_ptr[3], m_addr[3], m_data[3], m_pdata[3];
    bit m_we[3], m_full[3], m_ovf[3], m_pend[3];
    bit chk_en = 1'b0;

    task automatic model_step(input int d);
        int  sz;
        bit  wrap;
        bit  busy;
        int  need, left;
        sz   = (d == 1) ? 16 : 256;
        wrap = (d == 2);
        busy = m_we[d];
        if (rst) begin
            m_ptr[d] = 0; m_addr[d] = 0; m_data[d] = 0; m_pdata[d] = 0;
            m_we[d] = 0; m_full[d] = 0; m_ovf[d] = 0; m_pend[d] = 0;
            return;
        end
        if (m_we[d] && !m_pend[d] && !wrap && m_addr[d] == sz - 1)
            m_full[d] = 1'b1;
        if (m_pend[d]) begin
            m_we[d]   = 1'b1;
            m_addr[d] = m_ptr[d];
            m_data[d] = m_pdata[d];
            m_ptr[d]  = (m_ptr[d] + 1) % sz;
            m_pend[d] = 1'b0;
        end else begin
            m_we[d] = 1'b0;
            if (!busy) begin
                if (org_valid) begin
                    m_ptr[d]  = int'(org_addr) % sz;
                    m_full[d] = 1'b0;
                end else if (req_valid) begin
                    need = (req_src == SRC_IMM) ? 2 : 1;
                    left = m_full[d] ? 0 : (wrap ? 2 : sz - m_ptr[d]);
                    if (need > left) begin
                        m_ovf[d] = 1'b1;
                    end else begin
                        m_we[d]    = 1'b1;
                        m_addr[d]  = m_ptr[d];
                        m_data[d]  = int'(req_bit7) * 128 + int'(req_dst) * 16 +
                                     int'(req_bit3) * 8 + int'(req_src);
                        m_ptr[d]   = (m_ptr[d] + 1) % sz;
                        m_pend[d]  = (need == 2);
                        m_pdata[d] = int'(req_imm);
                    end
                end
            end
        end
    endtask

    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) model_step(d);
        if (rst) chk_en = 1'b1;
    end

    function automatic void chk(input string name, input int d,
                                input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d t=%0t actual=%0h expected=%0h", name, d, $time, act, exp);
        end
    endfunction

    task automatic cmp(input int d, input logic we, input logic [7:0] addr,
                       input logic [7:0] data, input logic [7:0] nxt,
                       input logic full, input logic ovf, input logic rdy);
        chk("mem_we",    d, 32'(we),   32'(m_we[d]));
        chk("mem_addr",  d, 32'(addr), m_addr[d]);
        chk("mem_wdata", d, 32'(data), m_data[d]);
        chk("next_addr", d, 32'(nxt),  m_ptr[d]);
        chk("full",      d, 32'(full), 32'(m_full[d]));
        chk("overflow",  d, 32'(ovf),  32'(m_ovf[d]));
        chk("req_ready", d, 32'(rdy),  32'(!m_we[d] && !org_valid));
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp(0, bus8.mem_we, bus8.mem_addr, bus8.mem_wdata, bus8.next_addr,
                bus8.full, bus8.overflow, bus8.req_ready);
            cmp(1, bus4.mem_we, {4'b0, bus4.mem_addr}, bus4.mem_wdata, {4'b0, bus4.next_addr},
                bus4.full, bus4.overflow, bus4.req_ready);
            cmp(2, busw.mem_we, busw.mem_addr, busw.mem_wdata, busw.next_addr,
                busw.full, busw.overflow, busw.req_ready);
        end
    end

    // ---------------- stimulus
    task automatic send(input logic [2:0] s, input logic [2:0] dd, input logic b3,
                        input logic b7, input logic [7:0] imm);
        @(posedge clk); #1;
        req_src = s; req_dst = dd; req_bit3 = b3; req_bit7 = b7; req_imm = imm;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic org(input logic [7:0] a);
        @(posedge clk); #1;
        org_addr = a; org_valid = 1'b1;
        @(posedge clk); #1;
        org_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic [2:0] s; logic [2:0] dd; logic b3; logic b7; logic [7:0] imm;
    } vec_t;

    vec_t vecs [6];

    initial begin
        rst = 1'b1; org_valid = 1'b0; org_addr = '0; req_valid = 1'b0;
        req_src = '0; req_dst = '0; req_bit3 = 1'b0; req_bit7 = 1'b0; req_imm = '0;
        vecs[0] = '{3'd7, 3'd6, 1'b0, 1'b0, 8'h00};
        vecs[1] = '{3'd0, 3'd7, 1'b1, 1'b0, 8'h3C};
        vecs[2] = '{3'd5, 3'd4, 1'b0, 1'b1, 8'h00};
        vecs[3] = '{3'd1, 3'd0, 1'b1, 1'b1, 8'h00};
        vecs[4] = '{3'd0, 3'd1, 1'b0, 1'b1, 8'hE1};
        vecs[5] = '{3'd6, 3'd5, 1'b1, 1'b0, 8'h00};
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_we",   0, 32'(bus8.mem_we),    32'h0);
        chk("rst_addr", 0, 32'(bus8.mem_addr),  32'h0);
        chk("rst_data", 0, 32'(bus8.mem_wdata), 32'h0);
        chk("rst_next", 0, 32'(bus8.next_addr), 32'h0);
        chk("rst_full", 0, 32'(bus8.full),      32'h0);
        chk("rst_ovf",  0, 32'(bus8.overflow),  32'h0);

        // T1: plain transfer
        send(3'd2, 3'd3, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        chk("t1_we",   0, 32'(bus8.mem_we),    32'h1);
        chk("t1_addr", 0, 32'(bus8.mem_addr),  32'h0);
        chk("t1_data", 0, 32'(bus8.mem_wdata), 32'h32);
        chk("t1_next", 0, 32'(bus8.next_addr), 32'h1);
        chk("t1_busy", 0, 32'(bus8.req_ready), 32'h0);
        @(negedge clk);
        chk("t1_rdy",  0, 32'(bus8.req_ready), 32'h1);

        // T2: immediate transfer from address 0
        org(8'h00);
        send(3'd0, 3'd2, 1'b0, 1'b0, 8'hA5);
        @(negedge clk);
        chk("t2_op",    0, 32'(bus8.mem_wdata), 32'h20);
        chk("t2_busy0", 0, 32'(bus8.req_ready), 32'h0);
        @(negedge clk);
        chk("t2_iaddr", 0, 32'(bus8.mem_addr),  32'h1);
        chk("t2_imm",   0, 32'(bus8.mem_wdata), 32'hA5);
        chk("t2_busy1", 0, 32'(bus8.req_ready), 32'h0);
        @(negedge clk);
        chk("t2_rdy",   0, 32'(bus8.req_ready), 32'h1);
        chk("t2_next",  0, 32'(bus8.next_addr), 32'h2);

        // T3: conditional jump encoding
        send(3'd4, 3'd1, 1'b1, 1'b1, 8'h00);
        @(negedge clk);
        chk("t3_data", 0, 32'(bus8.mem_wdata), 32'h9C);

        // T4/T5: imm instr at the top of memory
        org(8'hFF);
        send(3'd0, 3'd2, 1'b0, 1'b0, 8'h5A);
        @(negedge clk);
        chk("t4_nowr",   1, 32'(bus4.mem_we),    32'h0);
        chk("t5_op_a",   2, 32'(busw.mem_addr),  32'hFF);
        chk("t5_op_d",   2, 32'(busw.mem_wdata), 32'h20);
        @(negedge clk);
        chk("t4_ovf",    1, 32'(bus4.overflow),  32'h1);
        chk("t5_imm_a",  2, 32'(busw.mem_addr),  32'h00);
        chk("t5_imm_d",  2, 32'(busw.mem_wdata), 32'h5A);
        @(negedge clk);
        chk("t5_next",   2, 32'(busw.next_addr), 32'h1);
        chk("t5_nofull", 2, 32'(busw.full),      32'h0);

        send(3'd2, 3'd3, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        chk("t4_wr_a",   1, 32'(bus4.mem_addr),  32'hF);
        chk("t4_wr_we",  1, 32'(bus4.mem_we),    32'h1);
        @(negedge clk);
        chk("t4_full",   1, 32'(bus4.full),      32'h1);
        chk("t4_drain",  1, 32'(bus4.req_ready), 32'h1);
        send(3'd3, 3'd2, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        chk("t4_fullwr", 1, 32'(bus4.mem_we),    32'h0);
        org(8'h00);
        @(negedge clk);
        chk("t4_clr",    1, 32'(bus4.full),      32'h0);

        // org_valid beats a same-cycle request
        @(posedge clk); #1;
        org_addr = 8'h10; org_valid = 1'b1;
        req_src = 3'd2; req_dst = 3'd3; req_bit3 = 1'b0; req_bit7 = 1'b0; req_valid = 1'b1;
        @(negedge clk);
        chk("pri_rdy",  0, 32'(bus8.req_ready), 32'h0);
        @(posedge clk); #1;
        org_valid = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        chk("pri_next", 0, 32'(bus8.next_addr), 32'h10);
        chk("pri_we",   0, 32'(bus8.mem_we),    32'h0);

        for (int i = 0; i < 6; i++) begin
            send(vecs[i].s, vecs[i].dd, vecs[i].b3, vecs[i].b7, vecs[i].imm);
            idle(2);
        end

        // T6: reset during the opcode cycle
        send(3'd0, 3'd2, 1'b0, 1'b0, 8'h77);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t6_we",   0, 32'(bus8.mem_we),    32'h0);
        chk("t6_addr", 0, 32'(bus8.mem_addr),  32'h0);
        chk("t6_data", 0, 32'(bus8.mem_wdata), 32'h0);
        chk("t6_next", 0, 32'(bus8.next_addr), 32'h0);
        chk("t6_ovf",  1, 32'(bus4.overflow),  32'h0);
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
